// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencing controller: stall vectors,
// stage bit positions, the eret exception code and the FSM state type.
package pipe_ctrl_pkg;

  localparam int StagePc  = 0;
  localparam int StageIf  = 1;
  localparam int StageId  = 2;
  localparam int StageEx  = 3;
  localparam int StageMem = 4;
  localparam int StageWb  = 5;

  // A stalled stage also holds every stage upstream of it.
  localparam logic [5:0] StallNone = 6'b000000;
  localparam logic [5:0] StallId   = 6'((1 << StagePc) | (1 << StageIf) | (1 << StageId));
  localparam logic [5:0] StallEx   = StallId | 6'(1 << StageEx);
  localparam logic [5:0] StallMem  = StallEx | 6'(1 << StageMem);

  localparam logic [31:0] ExcEret   = 32'h0000_000e;
  localparam logic        RstEnable = 1'b1;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pipe_state_e;

endpackage

// File: rtl/stall_counter.sv
// 32-bit saturating event counter; counts clock edges while en is high.
module stall_counter
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      count <= ZeroWord;
    end else if (en && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges stage stall requests, sequences
// exception/eret flushes and converts over-long MEM waits into bus errors.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int          WD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        exc_valid,
  input  logic [31:0] excepttype,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        bus_err,
  output logic [31:0] stall_cycles
);

  localparam logic [7:0] WdLast = 8'(WD_TIMEOUT - 1);

  pipe_state_e state, state_nxt;
  logic [7:0]  wd_cnt, wd_cnt_nxt;
  logic [31:0] new_pc_q, new_pc_nxt;
  logic        bus_err_q, bus_err_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state     <= RUN;
      wd_cnt    <= 8'd0;
      new_pc_q  <= ZeroWord;
      bus_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      wd_cnt    <= wd_cnt_nxt;
      new_pc_q  <= new_pc_nxt;
      bus_err_q <= bus_err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    wd_cnt_nxt  = 8'd0;
    new_pc_nxt  = new_pc_q;
    bus_err_nxt = 1'b0;
    stall       = StallNone;
    case (state)
      RUN: begin
        if (exc_valid) begin
          state_nxt  = FLUSH;
          new_pc_nxt = (excepttype == ExcEret) ? cp0_epc : EXC_VECTOR;
        end else if (stallreq_mem && (wd_cnt == WdLast)) begin
          // The timeout cycle itself still holds the pipe; the flush follows.
          stall       = StallMem;
          state_nxt   = FLUSH;
          new_pc_nxt  = EXC_VECTOR;
          bus_err_nxt = 1'b1;
        end else begin
          if (stallreq_mem)     stall = StallMem;
          else if (stallreq_ex) stall = StallEx;
          else if (stallreq_id) stall = StallId;
          if (stallreq_mem) wd_cnt_nxt = wd_cnt + 8'd1;
        end
      end
      FLUSH: begin
        state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  assign flush   = (state == FLUSH);
  assign new_pc  = new_pc_q;
  assign bus_err = bus_err_q;

  stall_counter u_stall_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (|stall),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic
// compared against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam logic [31:0] EXC_VEC = 32'h0000_0020;
  localparam int          WD_TO   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem, exc_valid;
  logic [31:0] excepttype, cp0_epc;
  logic [5:0]  stall;
  logic        flush, bus_err;
  logic [31:0] new_pc, stall_cycles;

  int checks = 0;
  int failures = 0;

  // behavioural model state
  bit          m_flush;
  bit          m_buserr;
  logic [31:0] m_pc;
  int          m_wd;
  logic [31:0] m_cnt;
  int          n_buserr;

  pipe_ctrl #(.EXC_VECTOR(EXC_VEC), .WD_TIMEOUT(WD_TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .exc_valid    (exc_valid),
    .excepttype   (excepttype),
    .cp0_epc      (cp0_epc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .bus_err      (bus_err),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_flush  = 1'b0;
    m_buserr = 1'b0;
    m_pc     = 32'h0;
    m_wd     = 0;
    m_cnt    = 32'h0;
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, then
  // advance the model at the posedge and check the counter after it.
  task automatic cycle(input bit id, input bit ex, input bit mem, input bit exc,
                       input logic [31:0] etype, input logic [31:0] epc);
    logic [5:0] s_exp;
    int lvl;
    @(negedge clk);
    stallreq_id  = id;
    stallreq_ex  = ex;
    stallreq_mem = mem;
    exc_valid    = exc;
    excepttype   = etype;
    cp0_epc      = epc;
    #1;
    if (m_flush || exc) begin
      s_exp = 6'd0;
    end else begin
      lvl   = mem ? 3 : (ex ? 2 : (id ? 1 : 0));
      s_exp = (lvl == 0) ? 6'd0 : 6'((1 << (lvl + 2)) - 1);
    end
    check("stall", {26'd0, stall}, {26'd0, s_exp});
    check("flush", {31'd0, flush}, {31'd0, m_flush});
    check("bus_err", {31'd0, bus_err}, {31'd0, m_flush && m_buserr});
    if (m_flush) check("new_pc", new_pc, m_pc);
    if (bus_err) n_buserr++;
    @(posedge clk);
    if (s_exp != 6'd0 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (m_flush) begin
      m_flush  = 1'b0;
      m_buserr = 1'b0;
      m_wd     = 0;
    end else if (exc) begin
      m_flush  = 1'b1;
      m_buserr = 1'b0;
      m_pc     = (etype == 32'h0000_000e) ? epc : EXC_VEC;
    end else if (mem) begin
      m_wd = m_wd + 1;
      if (m_wd == WD_TO) begin
        m_flush  = 1'b1;
        m_buserr = 1'b1;
        m_pc     = EXC_VEC;
        m_wd     = 0;
      end
    end else begin
      m_wd = 0;
    end
    #1;
    check("stall_cycles", stall_cycles, m_cnt);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0; exc_valid = 0;
    excepttype = 32'h0; cp0_epc = 32'h0;
    n_buserr = 0;
    model_reset();
    #3;
    check("rst_stall", {26'd0, stall}, 32'h0);
    check("rst_flush", {31'd0, flush}, 32'h0);
    check("rst_new_pc", new_pc, 32'h0);
    check("rst_bus_err", {31'd0, bus_err}, 32'h0);
    check("rst_stall_cycles", stall_cycles, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // counter: five ID stalls from reset
    repeat (5) cycle(1, 0, 0, 0, 32'h0, 32'h0);
    check("cnt_five", stall_cycles, 32'd5);

    // priority
    idle();
    cycle(1, 1, 0, 0, 32'h0, 32'h0);
    cycle(1, 1, 1, 0, 32'h0, 32'h0);
    idle();

    // exception overrides an EX stall, then eret
    cycle(0, 1, 0, 1, 32'h8, 32'h0);
    cycle(0, 1, 0, 0, 32'h0, 32'h0);
    idle();
    cycle(0, 0, 0, 1, 32'he, 32'h0000_1234);
    idle();
    idle();

    // watchdog fires once on a 20-cycle MEM wait
    n_buserr = 0;
    repeat (20) cycle(0, 0, 1, 0, 32'h0, 32'h0);
    check("wd_pulses", n_buserr, 32'd1);
    idle();

    // watchdog restarts when MEM drops for one cycle
    n_buserr = 0;
    repeat (10) cycle(0, 0, 1, 0, 32'h0, 32'h0);
    idle();
    repeat (10) cycle(0, 0, 1, 0, 32'h0, 32'h0);
    check("wd_no_pulse", n_buserr, 32'd0);
    idle();

    // exception in the timeout cycle wins over the bus error
    n_buserr = 0;
    repeat (WD_TO - 1) cycle(0, 0, 1, 0, 32'h0, 32'h0);
    cycle(0, 0, 1, 1, 32'h4, 32'h0);
    cycle(0, 0, 1, 0, 32'h0, 32'h0);
    check("wd_exc_wins", n_buserr, 32'd0);
    idle();

    // saturation
    @(negedge clk);
    force dut.u_stall_counter.count = 32'hFFFF_FFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.u_stall_counter.count;
    m_cnt = 32'hFFFF_FFFE;
    repeat (3) cycle(1, 0, 0, 0, 32'h0, 32'h0);
    check("cnt_saturate", stall_cycles, 32'hFFFF_FFFF);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit r_mem, r_exc;
      r_mem = ($urandom_range(0, 9) != 0);
      r_exc = ($urandom_range(0, 24) == 0);
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), r_mem, r_exc,
            ($urandom_range(0, 1) == 0) ? 32'he : 32'($urandom_range(0, 31)),
            $urandom);
    end

    // reset in the middle of a flush
    idle();
    cycle(0, 0, 0, 1, 32'h8, 32'h0);
    @(negedge clk);
    stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0; exc_valid = 0;
    check("mid_flush_pre", {31'd0, flush}, 32'h1);
    rst = 1'b1;
    #1;
    check("mid_flush_flush", {31'd0, flush}, 32'h0);
    check("mid_flush_new_pc", new_pc, 32'h0);
    check("mid_flush_cnt", stall_cycles, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle(1, 0, 0, 0, 32'h0, 32'h0);
    check("post_rst_cnt", stall_cycles, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage core. It merges stall requests from ID, EX and MEM into a per-stage stall vector that freezes the pipeline registers (if_id, id_ex, ex_mem, mem_wb) and the PC. It also sequences exception and `eret` flushes, supplying the redirect PC. A watchdog converts an over-long MEM bus wait into a bus-error flush, and a saturating counter records stalled cycles.

## Interface
Parameters:
- EXC_VECTOR, 32'h0000_0020, redirect PC for all exceptions except `eret`.
- WD_TIMEOUT, 16, number of consecutive MEM-stall cycles that triggers a bus error. Legal range is 2..255.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stallreq_id  input  1  ID needs to hold (load-use hazard).
- stallreq_ex  input  1  EX needs to hold (multi-cycle mul/div).
- stallreq_mem  input  1  MEM bus not ready.
- exc_valid  input  1  MEM stage is committing an exception this cycle.
- excepttype  input  32  exception code; 32'h0000_000e means `eret`.
- cp0_epc  input  32  EPC value, used for `eret`.
- stall  output  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 means hold.
- flush  output  1  clear all pipeline registers to NOP.
- new_pc  output  32  PC to load while flush=1.
- bus_err  output  1  one-cycle pulse, coincident with a watchdog flush.
- stall_cycles  output  32  saturating count of cycles with stall!=0.

## Operation
- FSM has two states, RUN and FLUSH. It resets to RUN.
- Stall vector (combinational, RUN only):
  - stallreq_mem gives 6'b011111.
  - otherwise stallreq_ex gives 6'b001111.
  - otherwise stallreq_id gives 6'b000111.
  - otherwise 6'b000000.
  - The highest requesting stage wins, and its vector is a superset of the lower ones.
- Exception flush request in RUN with exc_valid=1:
  - stall=0 in that cycle; exc_valid overrides every stall request.
  - Latch new_pc = cp0_epc if excepttype==32'h0000_000e, else EXC_VECTOR.
  - Next state is FLUSH.
- Watchdog:
  - wd_cnt is 8 bits. It increments each RUN cycle in which stallreq_mem=1 and exc_valid=0.
  - It clears whenever stallreq_mem=0, and in FLUSH.
  - In a RUN cycle where wd_cnt==WD_TIMEOUT-1 and stallreq_mem=1 and exc_valid=0: latch new_pc=EXC_VECTOR, set the bus-error flag, next state is FLUSH.
  - If exc_valid=1 in that same cycle, exc_valid wins and no bus error is raised.
- FLUSH state:
  - flush=1 and stall=0.
  - bus_err=1 only when the flush was caused by the watchdog.
  - All inputs are ignored; exc_valid and stall requests are dropped.
  - Always returns to RUN after one cycle.
- new_pc holds its last latched value outside FLUSH. It is only meaningful while flush=1.
- stall_cycles:
  - Increments by 1 on every clock edge where stall!=0.
  - Saturates at 32'hFFFF_FFFF and never wraps.

## Timing
- Reset (asynchronous, immediate): state=RUN, wd_cnt=0, stall=0, flush=0, new_pc=0, bus_err=0, stall_cycles=0. Reset asserted mid-FLUSH aborts the flush immediately.
- stall has zero latency: it is combinational from the requests and the registered state.
- Flush latency: exc_valid sampled at edge N gives flush=1 for exactly the cycle between edges N and N+1. A watchdog flush follows the same timing.
- Minimum spacing between flushes is 2 cycles, because exc_valid is ignored in FLUSH.
- Bus-error timing: stallreq_mem held high from cycle 0 gives bus_err/flush in cycle WD_TIMEOUT. stall=6'b011111 in cycles 0..WD_TIMEOUT-1 and 0 in cycle WD_TIMEOUT.
- Watchdog reset: if stallreq_mem drops for one cycle, wd_cnt restarts from 0.

## Structure
- Shared defines.v holds:
  - the stall vector constants (StallNone, StallId, StallEx, StallMem),
  - the `eret` excepttype code,
  - the stage bit indices,
  - the RstEnable and ZeroWord constants.
- EXC_VECTOR stays a module parameter.
- One sub-module, stall_counter: a 32-bit saturating counter with an enable input.
- The FSM, watchdog and stall encoder stay inline in pipe_ctrl.

## Test plan
- Priority: stallreq_id=1 and stallreq_ex=1 together, then stallreq_mem=1 → stall=6'b001111, then 6'b011111. With no requests → stall=0 and flush=0.
- Exception: exc_valid=1 with excepttype=32'h8 while stallreq_ex=1 → stall=0 that cycle; next cycle flush=1, new_pc=32'h20, bus_err=0; following cycle flush=0.
- `eret`: excepttype=32'he, cp0_epc=32'h0000_1234 → next cycle flush=1, new_pc=32'h0000_1234.
- Watchdog (WD_TIMEOUT=16):
  - stallreq_mem held for 20 cycles → stall=6'b011111 in cycles 0–15; cycle 16 has flush=1, bus_err=1, new_pc=32'h20; cycle 17 resumes stall=6'b011111 with wd_cnt restarted.
  - Dropping stallreq_mem at cycle 10 prevents any bus_err.
- Counter:
  - 5 cycles of stallreq_id → stall_cycles=5.
  - Preload stall_cycles to 32'hFFFF_FFFE by force, then apply 3 stalled cycles → stall_cycles=32'hFFFF_FFFF.
- Reset mid-FLUSH: assert rst during the flush=1 cycle → flush, new_pc and stall_cycles go to 0 immediately. After release, a stallreq_id gives stall=6'b000111.
